// File: rtl/prng_xoshiro_sched.sv
// Seed/warm-up sequencer and round-robin word arbiter for an external xoshiro256+ core.
// Optional 2^128 jump sequencing is compiled in with `define PRNG_XOSHIRO_SCHED_JUMP_EN.
module prng_xoshiro_sched #(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_seedReq,
  input  logic [255:0]       i_seed,
  input  logic [N_REQ-1:0]   i_req,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [63:0]        o_data,
  output logic               o_seeded,
  output logic               o_busy,
  output logic               o_prngCg,
  output logic               o_prngSeedValid,
  output logic [255:0]       o_prngSeed,
  input  logic [255:0]       i_prngState,
  input  logic [63:0]        i_prngResult
`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
  ,
  input  logic               i_jumpReq
`endif
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);

`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
  typedef enum logic [2:0] {
    ST_UNSEEDED, ST_SEED, ST_WARM, ST_RUN, ST_JUMP, ST_JLOAD
  } state_t;
  // Bit k selects whether the k-th visited state is folded into the jump accumulator.
  localparam logic [255:0] JUMP_POLY = {64'h39abdc4529b1661c, 64'ha9582618e03fc9aa,
                                        64'hd5a61266f0c9392c, 64'h180ec6d33cfd0aba};
`else
  typedef enum logic [1:0] {
    ST_UNSEEDED, ST_SEED, ST_WARM, ST_RUN
  } state_t;
`endif

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [N_REQ-1:0]  gnt_raw;
  logic              hit;
  logic              run;
  logic              any_gnt;
  logic              prng_busy;
  logic [CW-1:0]     warm_cnt;
  logic              seeded_q;
  logic              busy_q;
  logic [255:0]      seed_q;

`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
  logic [255:0]      acc;
  logic [7:0]        jmp_cnt;
`else
  logic              unused_state;
  assign unused_state = ^i_prngState;
`endif

  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] p, input int i);
    int s = int'(p) + i;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  // Handshake: i_req is a level request; a high o_gnt bit is the same-cycle acceptance,
  // the requester takes o_data in that cycle and the word is never offered again.
  always_comb begin
    gnt_raw = '0;
    win     = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!hit && i_req[rot_idx(ptr, i)]) begin
        hit                      = 1'b1;
        gnt_raw[rot_idx(ptr, i)] = 1'b1;
        win                      = rot_idx(ptr, i);
      end
    end
  end

  assign run     = (state == ST_RUN);
  assign o_gnt   = run ? gnt_raw : '0;
  assign any_gnt = |o_gnt;
  assign o_data  = i_prngResult;

`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
  assign prng_busy       = (state == ST_SEED) || (state == ST_WARM) ||
                           (state == ST_JUMP) || (state == ST_JLOAD);
  assign o_prngSeedValid = (state == ST_SEED) || (state == ST_JLOAD);
  assign o_prngSeed      = (state == ST_JLOAD) ? acc : seed_q;
`else
  assign prng_busy       = (state == ST_SEED) || (state == ST_WARM);
  assign o_prngSeedValid = (state == ST_SEED);
  assign o_prngSeed      = seed_q;
`endif

  // The core advances only while sequencing or when a word is actually consumed.
  assign o_prngCg = prng_busy | any_gnt;
  assign o_seeded = seeded_q;
  assign o_busy   = busy_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_UNSEEDED;
      ptr      <= '0;
      warm_cnt <= '0;
      seeded_q <= 1'b0;
      busy_q   <= 1'b0;
      seed_q   <= '0;
`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
      acc      <= '0;
      jmp_cnt  <= '0;
`endif
    end else begin
      if (any_gnt) ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
      if (i_seedReq) begin
        seed_q   <= i_seed;
        state    <= ST_SEED;
        seeded_q <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          ST_UNSEEDED: state <= ST_UNSEEDED;
          ST_SEED: begin
            state    <= ST_WARM;
            warm_cnt <= WARM_LAST;
          end
          ST_WARM: begin
            if (warm_cnt == '0) begin
              state    <= ST_RUN;
              seeded_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              warm_cnt <= warm_cnt - CW'(1);
            end
          end
          ST_RUN: begin
`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
            if (i_jumpReq) begin
              state    <= ST_JUMP;
              seeded_q <= 1'b0;
              busy_q   <= 1'b1;
              acc      <= '0;
              jmp_cnt  <= '0;
            end
`else
            state <= ST_RUN;
`endif
          end
`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
          ST_JUMP: begin
            if (JUMP_POLY[jmp_cnt]) acc <= acc ^ i_prngState;
            if (jmp_cnt == 8'hFF) state <= ST_JLOAD;
            jmp_cnt <= jmp_cnt + 8'd1;
          end
          // After loading the jumped state one advance makes its s0+s3 the next word.
          ST_JLOAD: begin
            state    <= ST_WARM;
            warm_cnt <= '0;
          end
`endif
          default: state <= ST_UNSEEDED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prng_xoshiro_sched.sv
// Bench for prng_xoshiro_sched: behavioural xoshiro256+ core, reference word stream and
// round-robin model, directed plus randomized steps.
module tb_prng_xoshiro_sched;
  localparam int N = 4;
  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_req = 1'b0;
  logic         jump_req = 1'b0;
  logic [255:0] seed = '0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [63:0]  data;
  logic         seeded, busy, prng_cg, prng_sv;
  logic [255:0] prng_seed;
  logic [255:0] prng_s = '0;
  logic [63:0]  prng_res = '0;

  int errors = 0;
  int checks = 0;

  int           ptr = 0;
  int           hold = 0;
  int           load_at = 0;
  bit           seeded_m = 1'b0;
  logic [255:0] load_seed = '0;
  logic [255:0] run_s = '0;
  logic [63:0]  exp_q[$];
  logic [63:0]  last_word = '0;
  logic [255:0] sa, sb;

  always #5 clk = ~clk;

  prng_xoshiro_sched #(.N_REQ(N), .WARMUP(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_seedReq(seed_req), .i_seed(seed), .i_req(req),
    .o_gnt(gnt), .o_data(data), .o_seeded(seeded), .o_busy(busy),
    .o_prngCg(prng_cg), .o_prngSeedValid(prng_sv), .o_prngSeed(prng_seed),
    .i_prngState(prng_s), .i_prngResult(prng_res)
`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
    , .i_jumpReq(jump_req)
`endif
  );

  function automatic logic [255:0] nxt(input logic [255:0] s);
    logic [63:0] s0, s1, s2, s3, t;
    s0 = s[63:0]; s1 = s[127:64]; s2 = s[191:128]; s3 = s[255:192];
    t  = s1 << 17;
    s2 = s2 ^ s0; s3 = s3 ^ s1; s1 = s1 ^ s2; s0 = s0 ^ s3; s2 = s2 ^ t;
    s3 = {s3[18:0], s3[63:19]};
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [63:0] out_of(input logic [255:0] s);
    return s[63:0] + s[255:192];
  endfunction

  function automatic logic [255:0] jump_of(input logic [255:0] s_in);
    logic [255:0] jc, acc, s;
    jc  = {64'h39abdc4529b1661c, 64'ha9582618e03fc9aa, 64'hd5a61266f0c9392c, 64'h180ec6d33cfd0aba};
    acc = '0;
    s   = s_in;
    for (int k = 0; k < 256; k++) begin
      if (jc[k]) acc = acc ^ s;
      s = nxt(s);
    end
    return acc;
  endfunction

  function automatic logic [N-1:0] rr(input logic [N-1:0] r, input int p);
    logic [N-1:0] one;
    one = 1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (r[k]) return one << k;
    end
    return '0;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural core: load on cg+seedValid, otherwise register s0+s3 and advance.
  always @(posedge clk) begin
    if (prng_cg) begin
      if (prng_sv) prng_s <= prng_seed;
      else begin
        prng_res <= out_of(prng_s);
        prng_s   <= nxt(prng_s);
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [255:0] start, input int discard);
    logic [255:0] s;
    s = start;
    exp_q.delete();
    repeat (discard) s = nxt(s);
    run_s = nxt(s);
    for (int i = 0; i < 400; i++) begin
      exp_q.push_back(out_of(s));
      s = nxt(s);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input bit sr, input logic [255:0] sd, input bit jr);
    logic [N-1:0] eg;
    logic [63:0]  ew;
    bit           er;
    int           w;
    req = r; seed_req = sr; seed = sd; jump_req = jr;
    @(negedge clk);
    er = seeded_m && (hold == 0);
    eg = er ? rr(r, ptr) : '0;
    chk("gnt", gnt, eg);
    chk("prng_cg", prng_cg, (hold > 0) || (eg != 0));
    chk("seeded", seeded, er);
    chk("busy", busy, hold > 0);
    chk("seed_valid", prng_sv, (hold > 0) && (hold == load_at));
    if ((hold > 0) && (hold == load_at)) chk("prng_seed", prng_seed, load_seed);
    if (eg != 0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (eg[i]) w = i;
      ew = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("data", data, ew);
      last_word = data;
      ptr   = (w + 1) % N;
      run_s = nxt(run_s);
    end
    if (sr) begin
      seeded_m  = 1'b1;
      hold      = 1 + W;
      load_at   = 1 + W;
      load_seed = sd;
      fill(sd, W - 1);
    end
`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
    else if (jr && er) begin
      hold      = 258;
      load_at   = 2;
      load_seed = jump_of(run_s);
      fill(load_seed, 0);
    end
`endif
    else if (hold > 0) hold--;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", gnt, '0);
    chk("rst_seeded", seeded, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cg", prng_cg, 1'b0);
    chk("rst_seed_valid", prng_sv, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Unseeded: requests are ignored indefinitely.
    repeat (10) step(4'b1111, 1'b0, '0, 1'b0);

    sa = {64'd4, 64'd3, 64'd2, 64'd1};
    step(4'b0001, 1'b1, sa, 1'b0);
    step(4'b0001, 1'b0, '0, 1'b0);
    step(4'b0001, 1'b0, '0, 1'b0);
    step(4'b0001, 1'b0, '0, 1'b0);
    chk("first_word", last_word, 64'h5);
    step(4'b1000, 1'b0, '0, 1'b0);
    chk("second_word", last_word, 64'h0000C00000000007);

    // Full request vector: rotation 0,1,2,3,0.
    repeat (5) step(4'b1111, 1'b0, '0, 1'b0);

    step(4'b0000, 1'b0, '0, 1'b0);
    step(4'b0100, 1'b0, '0, 1'b0);
    step(4'b0000, 1'b0, '0, 1'b0);
    step(4'b1001, 1'b0, '0, 1'b0);
    step(4'b1001, 1'b0, '0, 1'b0);

    repeat (40) step(N'($urandom_range(0, 15)), 1'b0, '0, 1'b0);

    // Reseed mid-run, then the same seed again.
    sb = rand256();
    step(4'b1111, 1'b1, sb, 1'b0);
    repeat (1 + W + 5) step(4'b1111, 1'b0, '0, 1'b0);
    step(4'b1111, 1'b1, sb, 1'b0);
    repeat (1 + W + 5) step(4'b1111, 1'b0, '0, 1'b0);

    // A seed request during SEED restarts the sequence.
    step(4'b1111, 1'b1, sa, 1'b0);
    step(4'b1111, 1'b1, sb, 1'b0);
    repeat (6) step(4'b1111, 1'b0, '0, 1'b0);

    repeat (150) step(N'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0), rand256(), 1'b0);

`ifdef PRNG_XOSHIRO_SCHED_JUMP_EN
    step(4'b0000, 1'b1, sa, 1'b0);
    repeat (1 + W) step(4'b0000, 1'b0, '0, 1'b0);
    step(4'b0000, 1'b0, '0, 1'b1);
    repeat (258) step(4'b1111, 1'b0, '0, 1'b0);
    step(4'b0010, 1'b0, '0, 1'b0);
    chk("jump_first_word", last_word, out_of(jump_of(nxt(sa))));
    repeat (4) step(4'b1111, 1'b0, '0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
